// File: rtl/mux_scan_pkg.sv
// Shared definitions for the registered N-channel selector: state encoding,
// width helper and recovery of unused state encodings.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_MAN  = 2'b01,
    ST_SCAN = 2'b10
  } state_e;

  // Index width for v values; never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic state_e recover(input state_e s);
    case (s)
      ST_OFF, ST_MAN, ST_SCAN: return s;
      default:                 return ST_OFF;
    endcase
  endfunction

endpackage

// File: rtl/mux_nw.sv
// Combinational N:1 selector of W-bit words; flags an index outside 0..N-1
// and returns zero for it.
module mux_nw
  import mux_scan_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic [N*W-1:0]         din,
  input  logic [clog2(N)-1:0]    idx,
  output logic [W-1:0]           word,
  output logic                   out_of_range
);

  localparam int SEL_W = clog2(N);

  always_comb begin
    word         = '0;
    out_of_range = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (idx == SEL_W'(k)) begin
        word         = din[k*W +: W];
        out_of_range = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector with active-low enable, manual or round-robin
// scan selection, and a valid/ready output register.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int W     = 4,
  parameter int N     = 4,
  parameter int DWELL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_n,
  input  logic                  mode,
  input  logic [clog2(N)-1:0]   sel,
  input  logic [N*W-1:0]        din,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [W-1:0]          y,
  output logic [clog2(N)-1:0]   y_ch,
  output logic                  err
);

  localparam int SEL_W = clog2(N);
  localparam int DW_W  = clog2(DWELL);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d, ch_eff;
  logic [DW_W-1:0]    dwell_q, dwell_d, dwell_eff;
  logic [W-1:0]       y_q, y_d;
  logic [SEL_W-1:0]   y_ch_q, y_ch_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;
  logic               accept, enter_scan;
  logic [SEL_W-1:0]   idx;
  logic [W-1:0]       word;
  logic               oor;

  mux_nw #(.W(W), .N(N)) u_mux (
    .din          (din),
    .idx          (idx),
    .word         (word),
    .out_of_range (oor)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (!en_n) state_d = mode ? ST_SCAN : ST_MAN;
      ST_MAN:  if (en_n) state_d = ST_OFF; else if (mode) state_d = ST_SCAN;
      ST_SCAN: if (en_n) state_d = ST_OFF; else if (!mode) state_d = ST_MAN;
      default: state_d = recover(state_q);
    endcase
  end

  // Scan position restarts at channel 0 on the edge that enters scan mode,
  // and that same edge's capture already uses the restarted position.
  assign enter_scan = (state_d == ST_SCAN) && (state_q != ST_SCAN);
  assign ch_eff     = enter_scan ? '0 : ch_q;
  assign dwell_eff  = enter_scan ? '0 : dwell_q;
  assign idx        = mode ? ch_eff : sel;
  assign accept     = !en_n && (!vld_q || out_ready);

  always_comb begin
    ch_d    = ch_eff;
    dwell_d = dwell_eff;
    if (accept && mode) begin
      if (dwell_eff == DW_W'(DWELL - 1)) begin
        dwell_d = '0;
        ch_d    = (ch_eff == SEL_W'(N - 1)) ? '0 : ch_eff + 1'b1;
      end else begin
        dwell_d = dwell_eff + 1'b1;
      end
    end
  end

  always_comb begin
    y_d    = y_q;
    y_ch_d = y_ch_q;
    vld_d  = vld_q;
    err_d  = err_q;
    if (en_n) begin
      y_d   = '0;
      vld_d = 1'b0;
      err_d = 1'b0;
    end else if (accept) begin
      y_d    = oor ? '0 : word;
      y_ch_d = idx;
      err_d  = oor;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      ch_q    <= '0;
      dwell_q <= '0;
      y_q     <= '0;
      y_ch_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
      y_q     <= y_d;
      y_ch_q  <= y_ch_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = vld_q;
  assign y         = y_q;
  assign y_ch      = y_ch_q;
  assign err       = err_q;

endmodule
